axi_slave_ram: RTL and testbench
================================

Name: axi_slave_ram

Overview:
- AXI4 (no-lock, no-cache, no-prot) slave endpoint that attaches to one slave port of the bus interconnect and serves the opposite end of the handshake.
- Backs a word-addressed register/RAM array of 2**MEM_AW 32-bit words.
- Independent write and read engines, one outstanding transaction each; supports FIXED, INCR and WRAP bursts of 1-256 beats.
- Used as a scratchpad / control-register bank behind the interconnect, which has already translated addresses to slave-local offsets.

Parameters:
- S_ID, 4, ID width on the slave side; equals interconnect M_WIDTH+M_ID.
- MEM_AW, 8, log2 of the word count. Local byte window is 0 .. 2**(MEM_AW+2)-1.

Ports:
- BUS_CLK  in  1  bus clock.
- BUS_RSTN  in  1  reset: synchronous, active-low, sampled on the BUS_CLK rising edge.
- S_WR_ADDR_ID  in  S_ID  AW id.
- S_WR_ADDR  in  32  AW byte address, slave-local.
- S_WR_ADDR_LEN  in  8  beats-1.
- S_WR_ADDR_BURST  in  2  burst type.
- S_WR_ADDR_VALID  in  1.
- S_WR_ADDR_READY  out  1.
- S_WR_DATA  in  32.
- S_WR_STRB  in  4  byte enables.
- S_WR_DATA_LAST  in  1.
- S_WR_DATA_VALID  in  1.
- S_WR_DATA_READY  out  1.
- S_WR_BACK_ID  out  S_ID.
- S_WR_BACK_RESP  out  2.
- S_WR_BACK_VALID  out  1.
- S_WR_BACK_READY  in  1.
- S_RD_ADDR_ID  in  S_ID.
- S_RD_ADDR  in  32.
- S_RD_ADDR_LEN  in  8.
- S_RD_ADDR_BURST  in  2.
- S_RD_ADDR_VALID  in  1.
- S_RD_ADDR_READY  out  1.
- S_RD_BACK_ID  out  S_ID.
- S_RD_DATA  out  32.
- S_RD_DATA_RESP  out  2.
- S_RD_DATA_LAST  out  1.
- S_RD_DATA_VALID  out  1.
- S_RD_DATA_READY  in  1.

Behaviour:
- Reset values (BUS_RSTN=0 at a clock edge):
  - Both FSMs return to IDLE.
  - WR_ADDR_READY=1 and RD_ADDR_READY=1.
  - DATA_READY=0 and all VALID outputs =0.
  - BACK_ID, RESP, RD_DATA and LAST are 0.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; no response is issued.
- Write FSM:
  - W_IDLE: ADDR_READY=1. On AW handshake, latch id, addr[MEM_AW+1:2], len and burst; clear beat counter and error flag; go to W_DATA.
  - W_DATA: DATA_READY=1. Each W handshake writes the enabled bytes to the current word, then advances the address.
  - The burst ends on beat number len+1, regardless of LAST; then go to W_RESP.
  - LAST=1 on a non-final beat, or LAST=0 on the final beat, sets error.
  - W_RESP: BACK_VALID=1 with the latched id; RESP=SLVERR (2'b10) if error, else OKAY (2'b00). Hold until BACK_READY, then go to W_IDLE.
  - AW is accepted again only in W_IDLE.
- Read FSM:
  - R_IDLE: ADDR_READY=1. On AR handshake, latch the fields and go to R_DATA.
  - First RVALID appears exactly 1 cycle after the AR handshake; data is registered from mem[addr].
  - R_DATA: VALID=1. On each R handshake, the next beat's data is loaded in the same edge, giving 1 beat/cycle under continuous READY.
  - LAST=1 on beat len+1; after that beat's handshake go to R_IDLE.
  - VALID and data are stable while READY=0.
- Address generation (word units; addr[1:0] ignored):
  - FIXED (00): address constant.
  - INCR (01): address +1, wrapping at 2**MEM_AW.
  - WRAP (10), len in {1,3,7,15}: low log2(len+1) bits increment modulo len+1; upper bits fixed.
  - WRAP with any other len: behaves as INCR, RESP=OKAY.
  - Reserved (11): behaves as INCR; every write response and every read beat is SLVERR.
- Range check:
  - The start address with S_*_ADDR[31:MEM_AW+2] != 0 is out of range. The whole burst is then SLVERR.
  - Out-of-range writes are suppressed.
  - Out-of-range reads return RD_DATA=0 with RESP=SLVERR on every beat.
- Simultaneous events:
  - Read and write engines run concurrently.
  - A read of a word written on the same edge returns the old value; the write is visible from the next cycle.

Decomposition:
- Shared package axi_pkg holds:
  - burst constants BURST_FIXED/INCR/WRAP/RSVD;
  - response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - FSM state enums for the write and read engines.
- Sub-module axi_burst_addr_gen: combinational next-address computation from (addr, len, burst). Instantiated once per engine.

Test Plan:
- Single write then read: AW addr=0x10, len=0, INCR, id=4'h5; W data=0xDEADBEEF, strb=4'hF, LAST=1 → B id=5, RESP=00. AR addr=0x10 → RVALID 1 cycle after AR handshake, data=0xDEADBEEF, LAST=1, id=5.
- INCR burst with backpressure: write 4 beats at 0x20 with 0x11..0x44; read len=3 with RREADY toggling 1,0,1,0 → data 0x11,0x22,0x33,0x44 in order, LAST only on the 4th beat, data stable during stalls.
- WRAP: AR addr=0x38, len=3, WRAP → beats read words at 0x38, 0x3C, 0x30, 0x34. FIXED len=2 write to 0x40 with strb 4'h1 and data 0xA1,0xB2,0xC3 → the word's low byte =0xC3, other bytes unchanged.
- Errors:
  - Write len=1 with LAST=1 on beat 1 → two beats accepted, B RESP=10.
  - AR addr=0x1000 (MEM_AW=8) len=1 → two beats of data 0 with RESP=10.
  - BURST=2'b11 → RESP=10.
- Concurrency / reset: write burst len=7 and read burst len=7 issued together → both complete with OKAY. Assert BUS_RSTN=0 for 1 cycle during beat 3 of a new burst → next cycle all VALIDs=0, ADDR_READYs=1, no B response; a following transaction completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared constants and FSM state types for the AXI slave RAM.
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next word address of an AXI burst given the current beat address.
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int unsigned MEM_AW = 8
) (
   input  logic [MEM_AW-1:0] addr,
   input  logic [7:0]        len,
   input  logic [1:0]        burst,
   output logic [MEM_AW-1:0] next_addr
);

   logic [MEM_AW-1:0] incr;
   logic [MEM_AW-1:0] wrap_mask;

   assign incr = addr + MEM_AW'(1);

   // WRAP only for the legal lengths; anything else (and RSVD) degrades to INCR.
   always_comb begin
      wrap_mask = '0;
      next_addr = incr;
      if (burst == BURST_FIXED) begin
         next_addr = addr;
      end else if (burst == BURST_WRAP &&
                   (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
         wrap_mask = MEM_AW'(len);
         next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      end
   end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a 2**MEM_AW x 32-bit RAM; independent write and read engines.
module axi_slave_ram
   import axi_pkg::*;
#(
   parameter int unsigned S_ID   = 4,
   parameter int unsigned MEM_AW = 8
) (
   input  logic            BUS_CLK,
   input  logic            BUS_RSTN,
   input  logic [S_ID-1:0] S_WR_ADDR_ID,
   input  logic [31:0]     S_WR_ADDR,
   input  logic [7:0]      S_WR_ADDR_LEN,
   input  logic [1:0]      S_WR_ADDR_BURST,
   input  logic            S_WR_ADDR_VALID,
   output logic            S_WR_ADDR_READY,
   input  logic [31:0]     S_WR_DATA,
   input  logic [3:0]      S_WR_STRB,
   input  logic            S_WR_DATA_LAST,
   input  logic            S_WR_DATA_VALID,
   output logic            S_WR_DATA_READY,
   output logic [S_ID-1:0] S_WR_BACK_ID,
   output logic [1:0]      S_WR_BACK_RESP,
   output logic            S_WR_BACK_VALID,
   input  logic            S_WR_BACK_READY,
   input  logic [S_ID-1:0] S_RD_ADDR_ID,
   input  logic [31:0]     S_RD_ADDR,
   input  logic [7:0]      S_RD_ADDR_LEN,
   input  logic [1:0]      S_RD_ADDR_BURST,
   input  logic            S_RD_ADDR_VALID,
   output logic            S_RD_ADDR_READY,
   output logic [S_ID-1:0] S_RD_BACK_ID,
   output logic [31:0]     S_RD_DATA,
   output logic [1:0]      S_RD_DATA_RESP,
   output logic            S_RD_DATA_LAST,
   output logic            S_RD_DATA_VALID,
   input  logic            S_RD_DATA_READY
);

   localparam int unsigned DEPTH = 2 ** MEM_AW;

   logic [31:0] mem [DEPTH];

   // Byte-lane offset bits carry no meaning for a word-addressed array.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{S_WR_ADDR[1:0], S_RD_ADDR[1:0]};

   // ---------------- write engine ----------------
   wr_state_t         w_state_q, w_state_d;
   logic [S_ID-1:0]   w_id_q;
   logic [MEM_AW-1:0] w_addr_q, w_addr_nxt;
   logic [7:0]        w_len_q, w_cnt_q;
   logic [1:0]        w_burst_q;
   logic              w_err_q, w_oor_q;
   logic              aw_hs, w_hs, w_final, wr_oor;

   assign aw_hs   = S_WR_ADDR_VALID && S_WR_ADDR_READY;
   assign w_hs    = S_WR_DATA_VALID && S_WR_DATA_READY;
   assign w_final = (w_cnt_q == w_len_q);
   assign wr_oor  = |S_WR_ADDR[31:MEM_AW+2];

   axi_burst_addr_gen #(.MEM_AW(MEM_AW)) u_wr_addr_gen (
      .addr      (w_addr_q),
      .len       (w_len_q),
      .burst     (w_burst_q),
      .next_addr (w_addr_nxt)
   );

   // Write FSM state register.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RSTN) w_state_q <= W_IDLE;
      else           w_state_q <= w_state_d;
   end

   // Write FSM next state and handshake outputs.
   always_comb begin
      w_state_d       = w_state_q;
      S_WR_ADDR_READY = 1'b0;
      S_WR_DATA_READY = 1'b0;
      S_WR_BACK_VALID = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            S_WR_ADDR_READY = 1'b1;
            if (S_WR_ADDR_VALID) w_state_d = W_DATA;
         end
         W_DATA: begin
            S_WR_DATA_READY = 1'b1;
            if (S_WR_DATA_VALID && w_final) w_state_d = W_RESP;
         end
         W_RESP: begin
            S_WR_BACK_VALID = 1'b1;
            if (S_WR_BACK_READY) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Write burst context: latched on AW, advanced on every W beat.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RSTN) begin
         w_id_q    <= '0;
         w_addr_q  <= '0;
         w_len_q   <= '0;
         w_burst_q <= BURST_FIXED;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         w_oor_q   <= 1'b0;
      end else if (aw_hs) begin
         w_id_q    <= S_WR_ADDR_ID;
         w_addr_q  <= S_WR_ADDR[MEM_AW+1:2];
         w_len_q   <= S_WR_ADDR_LEN;
         w_burst_q <= S_WR_ADDR_BURST;
         w_cnt_q   <= '0;
         w_oor_q   <= wr_oor;
         w_err_q   <= wr_oor || (S_WR_ADDR_BURST == BURST_RSVD);
      end else if (w_hs) begin
         w_addr_q <= w_addr_nxt;
         w_cnt_q  <= w_cnt_q + 8'd1;
         // The beat count, not LAST, ends the burst; a disagreeing LAST is an error.
         if (S_WR_DATA_LAST != w_final) w_err_q <= 1'b1;
      end
   end

   assign S_WR_BACK_ID   = w_id_q;
   assign S_WR_BACK_RESP = (w_state_q == W_RESP && w_err_q) ? RESP_SLVERR : RESP_OKAY;

   // Byte-enabled RAM write; contents survive reset.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RSTN && w_hs && !w_oor_q) begin
         for (int b = 0; b < 4; b++) begin
            if (S_WR_STRB[b]) mem[w_addr_q][8*b +: 8] <= S_WR_DATA[8*b +: 8];
         end
      end
   end

   // ---------------- read engine ----------------
   rd_state_t         r_state_q, r_state_d;
   logic [S_ID-1:0]   r_id_q;
   logic [MEM_AW-1:0] r_addr_q, r_addr_nxt, ar_start;
   logic [7:0]        r_len_q, r_cnt_q;
   logic [1:0]        r_burst_q;
   logic              r_err_q, r_oor_q;
   logic [31:0]       r_data_q;
   logic              ar_hs, r_hs, r_final, rd_oor;

   assign ar_hs    = S_RD_ADDR_VALID && S_RD_ADDR_READY;
   assign r_hs     = S_RD_DATA_VALID && S_RD_DATA_READY;
   assign r_final  = (r_cnt_q == r_len_q);
   assign rd_oor   = |S_RD_ADDR[31:MEM_AW+2];
   assign ar_start = S_RD_ADDR[MEM_AW+1:2];

   axi_burst_addr_gen #(.MEM_AW(MEM_AW)) u_rd_addr_gen (
      .addr      (r_addr_q),
      .len       (r_len_q),
      .burst     (r_burst_q),
      .next_addr (r_addr_nxt)
   );

   // Read FSM state register.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RSTN) r_state_q <= R_IDLE;
      else           r_state_q <= r_state_d;
   end

   // Read FSM next state and handshake outputs.
   always_comb begin
      r_state_d       = r_state_q;
      S_RD_ADDR_READY = 1'b0;
      S_RD_DATA_VALID = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            S_RD_ADDR_READY = 1'b1;
            if (S_RD_ADDR_VALID) r_state_d = R_DATA;
         end
         R_DATA: begin
            S_RD_DATA_VALID = 1'b1;
            if (S_RD_DATA_READY && r_final) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Read burst context; next beat's data is fetched on the edge that retires the current one.
   always_ff @(posedge BUS_CLK) begin
      if (!BUS_RSTN) begin
         r_id_q    <= '0;
         r_addr_q  <= '0;
         r_len_q   <= '0;
         r_burst_q <= BURST_FIXED;
         r_cnt_q   <= '0;
         r_err_q   <= 1'b0;
         r_oor_q   <= 1'b0;
         r_data_q  <= '0;
      end else if (ar_hs) begin
         r_id_q    <= S_RD_ADDR_ID;
         r_addr_q  <= ar_start;
         r_len_q   <= S_RD_ADDR_LEN;
         r_burst_q <= S_RD_ADDR_BURST;
         r_cnt_q   <= '0;
         r_oor_q   <= rd_oor;
         r_err_q   <= rd_oor || (S_RD_ADDR_BURST == BURST_RSVD);
         r_data_q  <= rd_oor ? '0 : mem[ar_start];
      end else if (r_hs && !r_final) begin
         r_addr_q <= r_addr_nxt;
         r_cnt_q  <= r_cnt_q + 8'd1;
         r_data_q <= r_oor_q ? '0 : mem[r_addr_nxt];
      end
   end

   assign S_RD_BACK_ID   = r_id_q;
   assign S_RD_DATA      = r_data_q;
   assign S_RD_DATA_RESP = (r_state_q == R_DATA && r_err_q) ? RESP_SLVERR : RESP_OKAY;
   assign S_RD_DATA_LAST = (r_state_q == R_DATA) && r_final;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Scoreboard bench for axi_slave_ram: drivers push expectations, a monitor pops and compares.
module tb_axi_slave_ram;

   localparam int DEPTH = 256;
   localparam int LIMIT = 2000;

   logic        clk = 1'b0;
   logic        BUS_RSTN;
   logic [3:0]  S_WR_ADDR_ID, S_WR_BACK_ID, S_RD_ADDR_ID, S_RD_BACK_ID;
   logic [31:0] S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_DATA;
   logic [7:0]  S_WR_ADDR_LEN, S_RD_ADDR_LEN;
   logic [1:0]  S_WR_ADDR_BURST, S_RD_ADDR_BURST, S_WR_BACK_RESP, S_RD_DATA_RESP;
   logic [3:0]  S_WR_STRB;
   logic        S_WR_ADDR_VALID, S_WR_ADDR_READY, S_WR_DATA_LAST, S_WR_DATA_VALID;
   logic        S_WR_DATA_READY, S_WR_BACK_VALID, S_WR_BACK_READY;
   logic        S_RD_ADDR_VALID, S_RD_ADDR_READY, S_RD_DATA_LAST, S_RD_DATA_VALID;
   logic        S_RD_DATA_READY;

   always #5 clk = ~clk;

   axi_slave_ram #(.S_ID(4), .MEM_AW(8)) dut (
      .BUS_CLK         (clk),
      .BUS_RSTN        (BUS_RSTN),
      .S_WR_ADDR_ID    (S_WR_ADDR_ID),
      .S_WR_ADDR       (S_WR_ADDR),
      .S_WR_ADDR_LEN   (S_WR_ADDR_LEN),
      .S_WR_ADDR_BURST (S_WR_ADDR_BURST),
      .S_WR_ADDR_VALID (S_WR_ADDR_VALID),
      .S_WR_ADDR_READY (S_WR_ADDR_READY),
      .S_WR_DATA       (S_WR_DATA),
      .S_WR_STRB       (S_WR_STRB),
      .S_WR_DATA_LAST  (S_WR_DATA_LAST),
      .S_WR_DATA_VALID (S_WR_DATA_VALID),
      .S_WR_DATA_READY (S_WR_DATA_READY),
      .S_WR_BACK_ID    (S_WR_BACK_ID),
      .S_WR_BACK_RESP  (S_WR_BACK_RESP),
      .S_WR_BACK_VALID (S_WR_BACK_VALID),
      .S_WR_BACK_READY (S_WR_BACK_READY),
      .S_RD_ADDR_ID    (S_RD_ADDR_ID),
      .S_RD_ADDR       (S_RD_ADDR),
      .S_RD_ADDR_LEN   (S_RD_ADDR_LEN),
      .S_RD_ADDR_BURST (S_RD_ADDR_BURST),
      .S_RD_ADDR_VALID (S_RD_ADDR_VALID),
      .S_RD_ADDR_READY (S_RD_ADDR_READY),
      .S_RD_BACK_ID    (S_RD_BACK_ID),
      .S_RD_DATA       (S_RD_DATA),
      .S_RD_DATA_RESP  (S_RD_DATA_RESP),
      .S_RD_DATA_LAST  (S_RD_DATA_LAST),
      .S_RD_DATA_VALID (S_RD_DATA_VALID),
      .S_RD_DATA_READY (S_RD_DATA_READY)
   );

   typedef struct packed {logic [3:0] id; logic [1:0] resp;} b_exp_t;
   typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} r_exp_t;

   b_exp_t      exp_b[$];
   r_exp_t      exp_r[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wd [256];
   logic [3:0]  ws [256];
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout want handshake", name);
   endtask

   // Word address of beat i, straight from the burst rules.
   function automatic int beat_addr(input int start, input int len, input logic [1:0] burst,
                                    input int i);
      int n;
      n = len + 1;
      if (burst == 2'b00) return start;
      if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
         return (start / n) * n + ((start % n) + i) % n;
      return (start + i) % DEPTH;
   endfunction

   // Write burst using wd/ws; bad_beat flips LAST on that beat (-1 = well-formed).
   task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int bad_beat, input bit gaps);
      bit oor, err;
      int a, cnt;
      oor = (addr[31:10] != 0);
      err = oor || burst == 2'b11 || (bad_beat >= 0 && bad_beat <= len);
      if (!oor) begin
         for (int i = 0; i <= len; i++) begin
            a = beat_addr(int'(addr[9:2]), len, burst, i);
            for (int b = 0; b < 4; b++)
               if (ws[i][b]) ref_mem[a][8*b +: 8] = wd[i][8*b +: 8];
         end
      end
      exp_b.push_back({id, err ? 2'b10 : 2'b00});
      S_WR_ADDR_ID = id; S_WR_ADDR = addr; S_WR_ADDR_LEN = 8'(len);
      S_WR_ADDR_BURST = burst; S_WR_ADDR_VALID = 1'b1;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (S_WR_ADDR_READY) break;
         if (++cnt > LIMIT) begin fail_now("aw_wait"); break; end
      end
      @(posedge clk); #1;
      S_WR_ADDR_VALID = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if (gaps && $urandom_range(3) == 0) begin
            S_WR_DATA_VALID = 1'b0;
            @(posedge clk); #1;
         end
         S_WR_DATA = wd[i]; S_WR_STRB = ws[i];
         S_WR_DATA_LAST = (i == len) ^ (i == bad_beat);
         S_WR_DATA_VALID = 1'b1;
         cnt = 0;
         forever begin
            @(negedge clk);
            if (S_WR_DATA_READY) break;
            if (++cnt > LIMIT) begin fail_now("w_wait"); break; end
         end
         @(posedge clk); #1;
      end
      S_WR_DATA_VALID = 1'b0;
      S_WR_DATA_LAST = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      S_WR_BACK_READY = 1'b1;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (S_WR_BACK_VALID) break;
         if (++cnt > LIMIT) begin fail_now("b_wait"); break; end
      end
      @(posedge clk); #1;
      S_WR_BACK_READY = 1'b0;
   endtask

   // Read burst; mode 0 = READY held, 1 = READY toggles 1,0,1,0..., 2 = random READY.
   task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst, input int mode);
      bit oor;
      int a, cnt, got;
      oor = (addr[31:10] != 0);
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(int'(addr[9:2]), len, burst, i);
         exp_r.push_back({id, oor ? 32'h0 : ref_mem[a],
                          (oor || burst == 2'b11) ? 2'b10 : 2'b00, i == len});
      end
      S_RD_ADDR_ID = id; S_RD_ADDR = addr; S_RD_ADDR_LEN = 8'(len);
      S_RD_ADDR_BURST = burst; S_RD_ADDR_VALID = 1'b1;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (S_RD_ADDR_READY) break;
         if (++cnt > LIMIT) begin fail_now("ar_wait"); break; end
      end
      @(posedge clk); #1;
      S_RD_ADDR_VALID = 1'b0;
      got = 0;
      cnt = 0;
      while (got <= len && cnt < LIMIT) begin
         if (mode == 0)      S_RD_DATA_READY = 1'b1;
         else if (mode == 1) S_RD_DATA_READY = (cnt % 2 == 0);
         else                S_RD_DATA_READY = 1'($urandom_range(1));
         @(negedge clk);
         if (cnt == 0) chk("rvalid_latency", S_RD_DATA_VALID, 1);
         if (S_RD_DATA_VALID && S_RD_DATA_READY) got++;
         @(posedge clk); #1;
         cnt++;
      end
      S_RD_DATA_READY = 1'b0;
      if (got <= len) fail_now("r_beats");
   endtask

   // Monitor: pops expected responses on every handshake, checks R hold during stalls.
   bit          r_stall = 1'b0;
   logic [31:0] hold_data;
   logic        hold_last;
   always @(negedge clk) begin
      if (!BUS_RSTN) begin
         r_stall = 1'b0;
      end else begin
         if (r_stall) begin
            chk("r_hold_valid", S_RD_DATA_VALID, 1);
            chk("r_hold_data", S_RD_DATA, hold_data);
            chk("r_hold_last", S_RD_DATA_LAST, hold_last);
         end
         if (S_WR_BACK_VALID && S_WR_BACK_READY) begin
            if (exp_b.size() == 0) fail_now("b_unexpected");
            else begin
               b_exp_t e;
               e = exp_b.pop_front();
               chk("b_id", S_WR_BACK_ID, e.id);
               chk("b_resp", S_WR_BACK_RESP, e.resp);
            end
         end
         if (S_RD_DATA_VALID && S_RD_DATA_READY) begin
            if (exp_r.size() == 0) fail_now("r_unexpected");
            else begin
               r_exp_t e;
               e = exp_r.pop_front();
               chk("r_id", S_RD_BACK_ID, e.id);
               chk("r_data", S_RD_DATA, e.data);
               chk("r_resp", S_RD_DATA_RESP, e.resp);
               chk("r_last", S_RD_DATA_LAST, e.last);
            end
         end
         r_stall   = S_RD_DATA_VALID && !S_RD_DATA_READY;
         hold_data = S_RD_DATA;
         hold_last = S_RD_DATA_LAST;
      end
   end

   task automatic fill_rand(input int len);
      for (int i = 0; i <= len; i++) begin
         wd[i] = $urandom;
         ws[i] = 4'($urandom_range(15));
      end
   endtask

   initial begin
      int len, bb;
      logic [1:0]  burst;
      logic [31:0] addr;
      BUS_RSTN = 1'b0;
      S_WR_ADDR_ID = '0; S_WR_ADDR = '0; S_WR_ADDR_LEN = '0; S_WR_ADDR_BURST = '0;
      S_WR_ADDR_VALID = 0; S_WR_DATA = '0; S_WR_STRB = '0; S_WR_DATA_LAST = 0;
      S_WR_DATA_VALID = 0; S_WR_BACK_READY = 0; S_RD_ADDR_ID = '0; S_RD_ADDR = '0;
      S_RD_ADDR_LEN = '0; S_RD_ADDR_BURST = '0; S_RD_ADDR_VALID = 0; S_RD_DATA_READY = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_aw_ready", S_WR_ADDR_READY, 1);
      chk("rst_ar_ready", S_RD_ADDR_READY, 1);
      chk("rst_w_ready", S_WR_DATA_READY, 0);
      chk("rst_b_valid", S_WR_BACK_VALID, 0);
      chk("rst_r_valid", S_RD_DATA_VALID, 0);
      chk("rst_outs", {S_WR_BACK_ID, S_WR_BACK_RESP, S_RD_BACK_ID, S_RD_DATA, S_RD_DATA_RESP,
                       S_RD_DATA_LAST}, 0);
      @(posedge clk); #1;
      BUS_RSTN = 1'b1;

      // Fill the whole array with one 256-beat burst, then read it all back.
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      wr_burst(4'h1, 32'h0, 255, 2'b01, -1, 1'b0);
      rd_burst(4'h2, 32'h0, 255, 2'b01, 0);

      // Single write then read.
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      wr_burst(4'h5, 32'h10, 0, 2'b01, -1, 1'b0);
      rd_burst(4'h5, 32'h10, 0, 2'b01, 0);

      // INCR with toggling READY.
      wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
      for (int i = 0; i < 4; i++) ws[i] = 4'hF;
      wr_burst(4'h3, 32'h20, 3, 2'b01, -1, 1'b1);
      rd_burst(4'h3, 32'h20, 3, 2'b01, 1);

      // WRAP read and FIXED byte-strobed write.
      rd_burst(4'h6, 32'h38, 3, 2'b10, 0);
      wd[0] = 32'hA1; wd[1] = 32'hB2; wd[2] = 32'hC3;
      for (int i = 0; i < 3; i++) ws[i] = 4'h1;
      wr_burst(4'h7, 32'h40, 2, 2'b00, -1, 1'b0);
      rd_burst(4'h7, 32'h40, 0, 2'b01, 0);

      // Error cases: early LAST, out of range (writes suppressed, no alias), reserved burst.
      fill_rand(1);
      wr_burst(4'h8, 32'h80, 1, 2'b01, 0, 1'b0);
      rd_burst(4'h9, 32'h1000, 1, 2'b01, 0);
      fill_rand(0);
      wr_burst(4'hA, 32'h1010, 0, 2'b01, -1, 1'b0);
      rd_burst(4'hA, 32'h10, 0, 2'b01, 0);
      fill_rand(2);
      wr_burst(4'hB, 32'h90, 2, 2'b11, -1, 1'b0);
      rd_burst(4'hB, 32'h90, 2, 2'b11, 2);

      // Concurrent bursts on disjoint regions.
      fill_rand(7);
      fork
         wr_burst(4'hC, 32'h300, 7, 2'b01, -1, 1'b1);
         rd_burst(4'hD, 32'h000, 7, 2'b01, 2);
      join

      // Reset in the middle of a write burst and a stalled read burst.
      S_WR_ADDR_ID = 4'h2; S_WR_ADDR = 32'h200; S_WR_ADDR_LEN = 8'd7;
      S_WR_ADDR_BURST = 2'b01; S_WR_ADDR_VALID = 1'b1;
      S_RD_ADDR_ID = 4'h4; S_RD_ADDR = 32'h0; S_RD_ADDR_LEN = 8'd7;
      S_RD_ADDR_BURST = 2'b01; S_RD_ADDR_VALID = 1'b1;
      @(posedge clk); #1;
      S_WR_ADDR_VALID = 1'b0; S_RD_ADDR_VALID = 1'b0;
      S_WR_DATA_VALID = 1'b1; S_WR_STRB = 4'hF; S_WR_DATA_LAST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         S_WR_DATA = $urandom;
         @(posedge clk); #1;
      end
      BUS_RSTN = 1'b0;
      @(posedge clk); #1;
      BUS_RSTN = 1'b1;
      S_WR_DATA_VALID = 1'b0;
      @(negedge clk);
      chk("mid_rst_b_valid", S_WR_BACK_VALID, 0);
      chk("mid_rst_r_valid", S_RD_DATA_VALID, 0);
      chk("mid_rst_w_ready", S_WR_DATA_READY, 0);
      chk("mid_rst_aw_ready", S_WR_ADDR_READY, 1);
      chk("mid_rst_ar_ready", S_RD_ADDR_READY, 1);
      @(posedge clk); #1;
      S_WR_BACK_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_rst_no_b", S_WR_BACK_VALID, 0);
      end
      @(posedge clk); #1;
      S_WR_BACK_READY = 1'b0;
      fill_rand(7);
      for (int i = 0; i < 8; i++) ws[i] = 4'hF;
      wr_burst(4'hE, 32'h200, 7, 2'b01, -1, 1'b0);
      rd_burst(4'hE, 32'h200, 7, 2'b01, 0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3) == 0) len = (2 << $urandom_range(3)) - 1;
         else len = $urandom_range(0, 20);
         burst = ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2));
         addr = 32'($urandom_range(0, 1023));
         if ($urandom_range(7) == 0) addr = addr | (32'h1 << $urandom_range(10, 31));
         if (n % 2 == 0) begin
            bb = ($urandom_range(4) == 0) ? $urandom_range(0, len) : -1;
            fill_rand(len);
            wr_burst(4'($urandom), addr, len, burst, bb, 1'b1);
         end else begin
            rd_burst(4'($urandom), addr, len, burst, $urandom_range(2));
         end
      end

      repeat (4) @(posedge clk);
      chk("b_queue_empty", exp_b.size(), 0);
      chk("r_queue_empty", exp_r.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
